adder_gear_2c: RTL and testbench

- Registered GeAr (Generic Accuracy-configurable) approximate adder for two's-complement operands; used in the systolic-array PE accumulation path.
- The WIDTH_B-bit sum is built from overlapping (R+P)-bit sub-adders. Each sub-adder after the first predicts its carry from its P low overlap bits only, so carries longer than P bits across a sub-adder boundary are dropped.
- The result is registered: one cycle latency.

---
 rtl/adder_gear_pkg.sv | 28 ++
 rtl/gear_sub_adder.sv | 20 ++
 rtl/adder_gear_2c.sv | 86 ++++++++
 tb/tb_adder_gear_2c.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adder_gear_pkg.sv
// -----------------------------------------------------------------------------
// adder_gear_pkg
// Shared geometry helpers for the GeAr approximate adder.
//   gear_num_sub(n, r, p) : number of overlapping sub-adders K for an n-bit sum
//   gear_valid(n, r, p)   : 1 when (r, p) tile an n-bit sum exactly
// -----------------------------------------------------------------------------
package adder_gear_pkg;

    // K = (N - L)/R + 1, with L = R + P.
    function automatic int gear_num_sub(input int n, input int r, input int p);
        return ((n - (r + p)) / r) + 1;
    endfunction

    // The sub-adder windows must fit inside N and step by R to land exactly
    // on the top bit, otherwise the result slices would leave gaps.
    function automatic bit gear_valid(input int n, input int r, input int p);
        if (r < 1)
            return 1'b0;
        if (p < 0)
            return 1'b0;
        if ((r + p) > n)
            return 1'b0;
        if (((n - (r + p)) % r) != 0)
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/gear_sub_adder.sv
// -----------------------------------------------------------------------------
// gear_sub_adder
// Plain L-bit adder used as one window of the GeAr adder. The carry-out is
// intentionally not produced: every window's carry-out is discarded.
//   a, b : L-bit addends
//   cin  : carry-in
//   sum  : L-bit sum (mod 2^L)
// -----------------------------------------------------------------------------
module gear_sub_adder #(
    parameter int L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L-1:0] sum
);

    assign sum = a + b + L'(cin);

endmodule

// File: rtl/adder_gear_2c.sv
// -----------------------------------------------------------------------------
// adder_gear_2c
// Registered GeAr approximate adder for two's-complement operands.
// The N-bit sum is assembled from K overlapping (R+P)-bit windows; each window
// after the first sees only its P low overlap bits to predict its carry, so
// carry chains longer than P bits across a window boundary are lost.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears OUT
//   A     : WIDTH_A-bit operand, sign-extended or truncated to N bits
//   B     : WIDTH_B-bit operand (N = WIDTH_B)
//   Carry : carry-in to window 0 only
//   OUT   : registered approximate sum mod 2^N, one cycle latency
// -----------------------------------------------------------------------------
module adder_gear_2c
    import adder_gear_pkg::*;
#(
    parameter int R       = 4,
    parameter int P       = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic               Carry,
    output logic [WIDTH_B-1:0] OUT
);

    localparam int N = WIDTH_B;
    localparam int L = R + P;
    localparam int K = gear_num_sub(N, R, P);

    if (!gear_valid(N, R, P)) begin : g_bad_geometry
        $error("adder_gear_2c: illegal geometry R=%0d P=%0d N=%0d", R, P, N);
    end

    logic [N-1:0] a_ext;
    logic [N-1:0] sum_approx;
    logic [L-1:0] sub_sum [K];

    // Align A to the sum width: sign-extend a narrow operand, keep the LSBs
    // of a wide one.
    if (WIDTH_A < N) begin : g_a_sext
        assign a_ext = {{(N - WIDTH_A){A[WIDTH_A-1]}}, A};
    end else if (WIDTH_A > N) begin : g_a_trunc
        logic unused_a_msbs;
        assign a_ext         = A[N-1:0];
        assign unused_a_msbs = ^A[WIDTH_A-1:N];
    end else begin : g_a_same
        assign a_ext = A;
    end

    // Window i covers bits [i*R+L-1 : i*R]. Window 0 supplies all of its L
    // bits; later windows supply only their upper R bits, the lower P bits
    // exist purely to predict the carry into those R bits.
    for (genvar i = 0; i < K; i++) begin : g_sub
        gear_sub_adder #(
            .L(L)
        ) u_sub (
            .a   (a_ext[i*R +: L]),
            .b   (B[i*R +: L]),
            .cin ((i == 0) ? Carry : 1'b0),
            .sum (sub_sum[i])
        );

        if (i == 0) begin : g_first
            assign sum_approx[L-1:0] = sub_sum[0];
        end else begin : g_rest
            assign sum_approx[i*R+P +: R] = sub_sum[i][L-1:P];
            if (P > 0) begin : g_pred_drop
                logic unused_pred_bits;
                assign unused_pred_bits = ^sub_sum[i][(P > 0 ? P-1 : 0):0];
            end
        end
    end

    // Output register; reset wins over the sum in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            OUT <= '0;
        else
            OUT <= sum_approx;
    end

endmodule

// File: tb/tb_adder_gear_2c.sv
// -----------------------------------------------------------------------------
// tb_adder_gear_2c
// Self-checking bench for adder_gear_2c at default geometry (R=4, P=4, N=16).
// Expected values come from spec constants and an arithmetic GeAr model.
// -----------------------------------------------------------------------------
module tb_adder_gear_2c;

    localparam int R_TB = 4;
    localparam int P_TB = 4;
    localparam int N_TB = 16;
    localparam int L_TB = R_TB + P_TB;
    localparam int K_TB = (N_TB - L_TB) / R_TB + 1;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        carry_in;
    logic [15:0] out_q;

    int n_compared;
    int n_failed;
    int n_inexact;

    adder_gear_2c #(
        .R(R_TB),
        .P(P_TB),
        .WIDTH_A(16),
        .WIDTH_B(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a_in),
        .B     (b_in),
        .Carry (carry_in),
        .OUT   (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GeAr reference: each window is an independent (R+P)-bit addition of the
    // operand bits it spans; window 0 contributes all L bits, the others their
    // top R bits.
    function automatic logic [15:0] gear_ref(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic cin);
        int res;
        int win;
        int lmask;
        int rmask;
        res   = 0;
        lmask = (1 << L_TB) - 1;
        rmask = (1 << R_TB) - 1;
        for (int i = 0; i < K_TB; i++) begin
            win = ((int'(a) >> (i * R_TB)) & lmask)
                + ((int'(b) >> (i * R_TB)) & lmask)
                + ((i == 0) ? int'(cin) : 0);
            if (i == 0)
                res = win & lmask;
            else
                res = res | (((win >> P_TB) & rmask) << (i * R_TB + P_TB));
        end
        return res[15:0];
    endfunction

    // Present one operand set before the next rising edge.
    task automatic drive(input logic r, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        @(negedge clk);
        rst      = r;
        a_in     = a;
        b_in     = b;
        carry_in = c;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        n_compared++;
        if (out_q !== 16'h0000) begin
            n_failed++;
            $display("FAIL reset: OUT=%h expected=%h", out_q, 16'h0000);
        end
        drive(1'b0, 16'h0005, 16'h000A, 1'b0);
        @(posedge clk);
        #1;
        n_compared++;
        if (out_q !== 16'h000F) begin
            n_failed++;
            $display("FAIL after_reset: OUT=%h expected=%h", out_q, 16'h000F);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [7];
        logic [15:0] vb [7];
        logic        vc [7];
        logic [15:0] ve [7];
        va[0] = 16'h0FFF; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = 16'h0F00;
        va[1] = 16'hFFF6; vb[1] = 16'h0005; vc[1] = 1'b0; ve[1] = 16'hFFFB;
        va[2] = 16'hFFFF; vb[2] = 16'h0001; vc[2] = 1'b0; ve[2] = 16'hFF00;
        va[3] = 16'h8000; vb[3] = 16'h8000; vc[3] = 1'b0; ve[3] = 16'h0000;
        va[4] = 16'h0000; vb[4] = 16'h0000; vc[4] = 1'b1; ve[4] = 16'h0001;
        va[5] = 16'h00FE; vb[5] = 16'h0001; vc[5] = 1'b1; ve[5] = 16'h0000;
        va[6] = 16'h0123; vb[6] = 16'h0456; vc[6] = 1'b0; ve[6] = 16'h0579;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, va[i], vb[i], vc[i]);
            @(posedge clk);
            #1;
            n_compared++;
            if (out_q !== ve[i]) begin
                n_failed++;
                $display("FAIL directed_%0d: A=%h B=%h C=%b OUT=%h expected=%h",
                         i, va[i], vb[i], vc[i], out_q, ve[i]);
            end
        end
    endtask

    // Reset asserted with live operands must still clear OUT, and the hold
    // value must stay until the next edge.
    task automatic test_reset_override();
        drive(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        n_compared++;
        if (out_q !== 16'h3333) begin
            n_failed++;
            $display("FAIL pre_override: OUT=%h expected=%h", out_q, 16'h3333);
        end
        drive(1'b1, 16'h7777, 16'h0001, 1'b1);
        @(posedge clk);
        #1;
        n_compared++;
        if (out_q !== 16'h0000) begin
            n_failed++;
            $display("FAIL reset_override: OUT=%h expected=%h", out_q, 16'h0000);
        end
        rst = 1'b0;
    endtask

    // Back-to-back random operands, one new pair every cycle.
    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] exp_gear;
        logic [15:0] exp_exact;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom_range(0, 1));
            exp_gear  = gear_ref(a, b, c);
            exp_exact = a + b + 16'(c);
            drive(1'b0, a, b, c);
            @(posedge clk);
            #1;
            n_compared++;
            if (out_q !== exp_gear) begin
                n_failed++;
                $display("FAIL random_%0d: A=%h B=%h C=%b OUT=%h expected=%h",
                         i, a, b, c, out_q, exp_gear);
            end
            if (out_q !== exp_exact)
                n_inexact++;
        end
        $display("[TB] random: %0d of 200 results differ from the exact sum (allowed)",
                 n_inexact);
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        n_inexact  = 0;
        rst        = 1'b1;
        a_in       = '0;
        b_in       = '0;
        carry_in   = 1'b0;
        test_reset();
        test_directed();
        test_reset_override();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
